// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite drawing datapaths and the VGA
// pixel-port arbiter.
//   SCREEN_X_W / SCREEN_Y_W / COLOUR_W : VGA adapter coordinate and colour widths
//   SPRITE_DIM / SPRITE_PIXELS         : sprite edge length and pixel count
//   arb_state_e                        : arbiter FSM state encoding
package sprite_pkg;

  localparam int unsigned SCREEN_X_W    = 8;
  localparam int unsigned SCREEN_Y_W    = 7;
  localparam int unsigned COLOUR_W      = 3;
  localparam int unsigned SPRITE_DIM    = 5;
  localparam int unsigned SPRITE_PIXELS = SPRITE_DIM * SPRITE_DIM;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder.
// Searches req starting at rr_ptr and wrapping around; the first set bit wins.
//   req     : request vector
//   rr_ptr  : index with highest priority this cycle
//   winner  : index of the selected requester (0 when none)
//   any_req : at least one request is pending
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [PTR_W-1:0] winner,
  output logic             any_req
);

  // One spare bit so rr_ptr + i cannot overflow before the wrap subtraction.
  logic [PTR_W:0] idx;

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
      if (idx >= (PTR_W + 1)'(N_REQ)) begin
        idx = idx - (PTR_W + 1)'(N_REQ);
      end
      if (!any_req && req[idx[PTR_W-1:0]]) begin
        any_req = 1'b1;
        winner  = idx[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sprite_plot_arbiter.sv
// Shares the single VGA adapter pixel-write port among N_REQ sprite drawers.
// A requester owns the port for a whole sprite pass; grants rotate round-robin
// between passes, so pixels of different sprites never interleave.
//   clock, reset            : clock, synchronous active-high reset
//   req/pix_valid/pix_last  : per-requester burst request, pixel strobe, final pixel
//   x_in/y_in/colour_in     : packed per-requester pixel data (slice k belongs to k)
//   gnt                     : one-hot registered grant
//   vga_x/vga_y/vga_colour  : registered pixel to the VGA adapter
//   vga_plot                : registered write strobe
//   busy                    : a burst is in progress
//   overrun                 : sticky, a burst reached MAX_BURST without pix_last
module sprite_plot_arbiter
  import sprite_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_BURST = SPRITE_PIXELS,
  parameter int unsigned PTR_W     = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ-1:0]             pix_valid,
  input  logic [N_REQ-1:0]             pix_last,
  input  logic [SCREEN_X_W*N_REQ-1:0]  x_in,
  input  logic [SCREEN_Y_W*N_REQ-1:0]  y_in,
  input  logic [COLOUR_W*N_REQ-1:0]    colour_in,
  output logic [N_REQ-1:0]             gnt,
  output logic [SCREEN_X_W-1:0]        vga_x,
  output logic [SCREEN_Y_W-1:0]        vga_y,
  output logic [COLOUR_W-1:0]          vga_colour,
  output logic                         vga_plot,
  output logic                         busy,
  output logic                         overrun
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e       state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] next_ptr;
  logic [CNT_W-1:0] count;
  logic             any_req;
  logic             accept;
  logic             at_limit;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    next_ptr = (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + PTR_W'(1);
    // Dropping req outranks a pixel presented in the same cycle.
    accept   = (state == BURST) & gnt[owner] & req[owner] & pix_valid[owner];
    at_limit = (count + CNT_W'(1)) == CNT_W'(MAX_BURST);
  end

  assign busy = (state == BURST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      count      <= '0;
      gnt        <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      vga_plot <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            gnt   <= {{(N_REQ - 1){1'b0}}, 1'b1} << winner;
            owner <= winner;
            count <= '0;
            state <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            vga_x      <= x_in[32'(owner) * SCREEN_X_W +: SCREEN_X_W];
            vga_y      <= y_in[32'(owner) * SCREEN_Y_W +: SCREEN_Y_W];
            vga_colour <= colour_in[32'(owner) * COLOUR_W +: COLOUR_W];
            vga_plot   <= 1'b1;
            count      <= count + CNT_W'(1);
            if (!pix_last[owner] && at_limit) begin
              overrun <= 1'b1;
            end
          end
          if (!req[owner] || (accept && (pix_last[owner] || at_limit))) begin
            gnt    <= '0;
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
